// File: rtl/nonce_unpacker.sv
// rtl/nonce_unpacker.sv - qualifies padded {crc12, nonce} words and queues each new nonce once
// Stability filter, crc12 check, SYNC/RUN dedup FSM and a first-word-fall-through result FIFO.

module nonce_crc12 (
  input  logic [31:0] data,
  output logic [11:0] crc
);
  // CRC-12, polynomial x^12+x^11+x^3+x^2+x+1, zero init, MSB first, no final xor
  function automatic logic [11:0] calc(input logic [31:0] d);
    logic [11:0] c;
    logic        fb;
    c = '0;
    for (int i = 31; i >= 0; i--) begin
      fb = c[11] ^ d[i];
      c  = {c[10:0], 1'b0};
      if (fb) c = c ^ 12'h80F;
    end
    return c;
  endfunction

  assign crc = calc(data);
endmodule

module nonce_unpacker #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH_LOG2    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [43:0] padded_in,
  output logic [31:0] out_nonce,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        crc_err,
  output logic        overflow,
  output logic [15:0] found_count,
  output logic [7:0]  err_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t              state, next_state;
  logic [43:0]         pin_q, cand;
  logic [CW-1:0]       stab_cnt;
  logic [11:0]         calc_crc;
  logic                qual, good;
  logic                base_load, new_nonce, bad_word;
  logic [31:0]         last_nonce;
  logic [31:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                empty, full, push, pop, drop;

  nonce_crc12 u_crc (
    .data (cand[31:0]),
    .crc  (calc_crc)
  );

  // qual is the one cycle in which the counter steps up to STABLE_CYCLES
  assign qual = (pin_q == cand) && (stab_cnt == CW'(STABLE_CYCLES - 1));
  assign good = (cand[43:32] == calc_crc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pin_q    <= '0;
      cand     <= '0;
      stab_cnt <= '0;
    end else begin
      pin_q <= padded_in;
      if (pin_q != cand) begin
        cand     <= pin_q;
        stab_cnt <= '0;
      end else if (stab_cnt < CW'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    base_load  = 1'b0;
    new_nonce  = 1'b0;
    bad_word   = 1'b0;
    if (qual) begin
      if (!good) begin
        bad_word = 1'b1;
      end else if (state == SYNC) begin
        // whatever sat on the bus out of reset becomes the baseline, never reported
        base_load  = 1'b1;
        next_state = RUN;
      end else if (cand[31:0] != last_nonce) begin
        new_nonce = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_nonce <= '0;
    else if (base_load || new_nonce) last_nonce <= cand[31:0];
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign out_valid = !empty;
  assign out_nonce = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign pop       = out_valid && out_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign push      = new_nonce && (!full || pop);
  assign drop      = new_nonce && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= cand[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_err     <= 1'b0;
      overflow    <= 1'b0;
      found_count <= '0;
      err_count   <= '0;
    end else begin
      crc_err <= bad_word;
      if (drop) overflow <= 1'b1;
      if (push && found_count != 16'hFFFF) found_count <= found_count + 16'd1;
      if (bad_word && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule
